axi_lite_host_master: RTL

- AXI-lite initiator that drives the accelerator SoC's 4-bit-address AXI-lite slave port (AW/W/AR/R channels only; the slave has no B channel).
- Takes queued register read/write commands from host-side logic or a bench, runs each one as an AXI-lite transaction, and returns one in-order response per command.
- Replaces hand-toggled AXI stimulus in system benches and host glue.

---
 rtl/axi_lite_host_master.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_host_master.sv
// -----------------------------------------------------------------------------
// axi_lite_host_master
//
// AXI-lite initiator for the accelerator SoC register port (AW/W/AR/R only,
// the slave has no B channel). Register read/write commands are queued in a
// small FIFO. Each command runs as one AXI-lite transaction. Exactly one
// response per command is returned, in command order.
//
// Optional feature macro: AXI_TIMEOUT_EN
//   Defined     : per-handshake watchdog. After TIMEOUT_CYCLES cycles in WR,
//                 RD_ADDR or RD_DATA the transaction is aborted and answered
//                 with rsp_err = 1. The queued commands are kept.
//   Not defined : no watchdog. rsp_err is tied to 0, and a stalled slave
//                 blocks the FSM.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   cmd_valid / cmd_ready     command handshake (cmd_ready = FIFO not full)
//   cmd_write                 1 = write, 0 = read
//   cmd_addr, cmd_wdata       register address, write data (ignored on reads)
//   rsp_valid / rsp_ready     response handshake; response held until taken
//   rsp_write                 response belongs to a write
//   rsp_rdata                 read data (0 for writes and aborted reads)
//   rsp_err                   transaction aborted by the watchdog
//   busy                      FIFO non-empty, FSM active or response pending
//   m_axi_aw*/w*/ar*/r*       AXI-lite master channels
// -----------------------------------------------------------------------------
module axi_lite_host_master #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [PTR_W:0] PTR_ONE = 1;

    // Elaboration-time parameter sanity check.
    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
            TIMEOUT_CYCLES < 1) begin : g_bad_params
            $error("axi_lite_host_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t state;

    // -------------------------------------------------------------------------
    // Command FIFO. The extra pointer bit tells full from empty.
    // -------------------------------------------------------------------------
    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              run_en;
    logic [ENT_W-1:0]  head;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // run_en keeps cmd_ready low while reset is asserted and for the first
    // clock afterwards, so no ready output is high during reset.
    assign cmd_ready  = run_en && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && !fifo_empty && !rsp_valid;

    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign head_write = head[ENT_W-1];
    assign head_addr  = head[ENT_W-2 -: ADDR_W];
    assign head_data  = head[DATA_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage only; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // -------------------------------------------------------------------------
    // Transaction FSM
    // -------------------------------------------------------------------------
    logic wr_done;
    logic ar_hs;
    logic r_hs;

    // A write is finished once each channel has either already completed
    // (valid dropped) or is completing this cycle.
    assign wr_done = (!m_axi_awvalid || m_axi_awready) &&
                     (!m_axi_wvalid  || m_axi_wready);
    assign ar_hs   = m_axi_arvalid && m_axi_arready;
    assign r_hs    = m_axi_rvalid  && m_axi_rready;

`ifdef AXI_TIMEOUT_EN
    localparam int TMO_CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W  = (TMO_CW > 8) ? TMO_CW : 8;
    localparam logic [TMO_W-1:0] TMO_ONE  = 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             step_done;
    logic             tmo_active;
    logic             tmo_hit;

    always_comb begin
        step_done  = 1'b0;
        tmo_active = 1'b0;
        case (state)
            WR: begin
                tmo_active = 1'b1;
                step_done  = wr_done;
            end
            RD_ADDR: begin
                tmo_active = 1'b1;
                step_done  = ar_hs;
            end
            RD_DATA: begin
                tmo_active = 1'b1;
                step_done  = r_hs;
            end
            default: begin
                tmo_active = 1'b0;
                step_done  = 1'b0;
            end
        endcase
    end

    // Fires on the edge that would start the TIMEOUT_CYCLES+1'th cycle in
    // the same state; a handshake landing on that edge still wins.
    assign tmo_hit = tmo_active && !step_done && (tmo_cnt == TMO_LAST);
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
`ifdef AXI_TIMEOUT_EN
            rsp_err       <= 1'b0;
            tmo_cnt       <= '0;
`endif
        end else begin
`ifdef AXI_TIMEOUT_EN
            // Counts cycles spent in the current handshake state; any state
            // change (including entry from IDLE) restarts from zero.
            if (tmo_active && !step_done) begin
                tmo_cnt <= tmo_cnt + TMO_ONE;
            end else begin
                tmo_cnt <= '0;
            end
`endif
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_write) begin
                            m_axi_awaddr  <= head_addr;
                            m_axi_wdata   <= head_data;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR;
                        end else begin
                            m_axi_araddr  <= head_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end
                    end
                end

                WR: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        m_axi_wvalid <= 1'b0;
                    end
                    if (wr_done) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end

                RD_ADDR: begin
                    if (ar_hs) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (r_hs) begin
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        state        <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_write <= 1'b0;
                        rsp_rdata <= '0;
`ifdef AXI_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef AXI_TIMEOUT_EN
            // Abort overrides whatever the state branch above scheduled.
            if (tmo_hit) begin
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
                rsp_valid     <= 1'b1;
                rsp_write     <= (state == WR);
                rsp_rdata     <= '0;
                rsp_err       <= 1'b1;
                state         <= RESP;
            end
`endif
        end
    end

    assign busy = !fifo_empty || (state != IDLE) || rsp_valid;

endmodule
